nzaa_ctrl: RTL and testbench

NZAA_CTRL -- requirements
Module: nzaa_ctrl

---
 rtl/nzaa_ctrl.sv | 132 +++++++++++++
 tb/tb_nzaa_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nzaa_ctrl.sv
// nzaa_ctrl: tile sequencer for a row accumulator.
// Streams ROWS reads per tile, drains, captures and hands off each result.
module nzaa_ctrl #(
  parameter  int ROWS  = 4096,
  parameter  int TILES = 63,
  parameter  int DW    = 256,
  localparam int RW    = $clog2(ROWS),
  localparam int WAW   = $clog2(ROWS*TILES),
  localparam int TW    = (TILES > 1) ? $clog2(TILES) : 1
) (
  input  logic           clk_h,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic [4:0]     th_cfg,
  output logic           busy,
  output logic           done,
  output logic           mem_rd,
  output logic [RW-1:0]  data_addr,
  output logic [WAW-1:0] weight_addr,
  output logic [4:0]     acc_th,
  output logic           acc_clear,
  output logic           acc_last_line,
  output logic           acc_wr,
  input  logic [DW-1:0]  acc_data_out,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [DW-1:0]  res_data,
  output logic [TW-1:0]  res_tile
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_STREAM, S_LAST, S_DRAIN1,
    S_DRAIN2, S_WRITE, S_CAPTURE, S_OUT, S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_nxt;
  logic [RW-1:0]  r_row;
  logic [WAW-1:0] r_waddr;
  logic [TW-1:0]  r_tile;
  logic [TW-1:0]  r_res_tile;
  logic [4:0]     r_th;
  logic [DW-1:0]  r_res_data;
  logic           w_kill;
  logic           w_accept;
  logic           w_row_end;
  logic           w_tile_end;
  logic           w_xfer;

  assign w_kill     = abort && (r_state != S_IDLE);
  assign w_accept   = (r_state == S_IDLE) && start && !abort;
  assign w_row_end  = (r_row == RW'(ROWS-1));
  assign w_tile_end = (r_tile == TW'(TILES-1));
  assign w_xfer     = (r_state == S_OUT) && res_ready;

  always_ff @(posedge clk_h) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    if (w_kill) begin
      w_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:    if (w_accept) w_nxt = S_CLEAR;
        S_CLEAR:   w_nxt = S_STREAM;
        S_STREAM:  if (w_row_end) w_nxt = S_LAST;
        S_LAST:    w_nxt = S_DRAIN1;
        S_DRAIN1:  w_nxt = S_DRAIN2;
        S_DRAIN2:  w_nxt = S_WRITE;
        S_WRITE:   w_nxt = S_CAPTURE;
        S_CAPTURE: w_nxt = S_OUT;
        S_OUT:
          if (res_ready) w_nxt = w_tile_end ? S_DONE : S_CLEAR;
        S_DONE:    w_nxt = S_IDLE;
        default:   w_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy          = (r_state != S_IDLE);
    done          = (r_state == S_DONE);
    acc_clear     = (r_state == S_CLEAR);
    mem_rd        = (r_state == S_CLEAR) || (r_state == S_STREAM);
    acc_last_line = (r_state == S_LAST);
    acc_wr        = (r_state == S_WRITE);
    res_valid     = (r_state == S_OUT);
    data_addr     = r_row;
    weight_addr   = r_waddr;
    acc_th        = r_th;
    res_data      = r_res_data;
    res_tile      = r_res_tile;
  end

  // Address counters hold the last issued read until the next tile starts.
  always_ff @(posedge clk_h) begin
    if (rst || w_kill) begin
      r_row      <= '0;
      r_waddr    <= '0;
      r_tile     <= '0;
      r_th       <= '0;
      r_res_data <= '0;
      r_res_tile <= '0;
    end else begin
      if (w_accept) begin
        r_th    <= th_cfg;
        r_tile  <= '0;
        r_row   <= '0;
        r_waddr <= '0;
      end
      if ((r_state == S_CLEAR) ||
          ((r_state == S_STREAM) && !w_row_end)) begin
        r_row   <= r_row + RW'(1);
        r_waddr <= r_waddr + WAW'(1);
      end
      if (r_state == S_CAPTURE) begin
        r_res_data <= acc_data_out;
        r_res_tile <= r_tile;
      end
      if (w_xfer && !w_tile_end) begin
        r_tile  <= r_tile + TW'(1);
        r_row   <= '0;
        r_waddr <= r_waddr + WAW'(1);
      end
    end
  end

endmodule

// File: tb/tb_nzaa_ctrl.sv
// tb_nzaa_ctrl: directed table, corner sequences and random
// stimulus against a schedule-based reference model.
module tb_nzaa_ctrl;
  localparam int ROWS  = 4;
  localparam int TILES = 2;
  localparam int DW    = 32;

  logic          clk_h = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          res_ready = 1'b0;
  logic [4:0]    th_cfg = '0;
  logic [DW-1:0] acc_data_out = '0;
  logic          busy, done, mem_rd, acc_clear;
  logic          acc_last_line, acc_wr, res_valid;
  logic [1:0]    data_addr;
  logic [2:0]    weight_addr;
  logic [4:0]    acc_th;
  logic [DW-1:0] res_data;
  logic [0:0]    res_tile;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_h = ~clk_h;

  nzaa_ctrl #(.ROWS(ROWS), .TILES(TILES), .DW(DW)) dut (
    .clk_h(clk_h), .rst(rst), .start(start), .abort(abort),
    .th_cfg(th_cfg), .busy(busy), .done(done), .mem_rd(mem_rd),
    .data_addr(data_addr), .weight_addr(weight_addr),
    .acc_th(acc_th), .acc_clear(acc_clear),
    .acc_last_line(acc_last_line), .acc_wr(acc_wr),
    .acc_data_out(acc_data_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data),
    .res_tile(res_tile)
  );

  // Reference model: m_k counts cycles since the tile's clear.
  bit            m_act, m_done;
  int            m_k, m_tile, m_da, m_wa, m_th, m_rtile;
  logic [DW-1:0] m_rdata;

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  function automatic void m_reset();
    m_act = 0; m_done = 0; m_k = 0; m_tile = 0;
    m_da = 0; m_wa = 0; m_th = 0; m_rtile = 0; m_rdata = '0;
  endfunction

  function automatic void m_step();
    if (rst) m_reset();
    else if (m_act && abort) m_reset();
    else if (m_done) begin
      m_done = 0; m_act = 0;
    end else if (!m_act) begin
      if (start && !abort) begin
        m_act = 1; m_tile = 0; m_k = 0; m_th = int'(th_cfg);
      end
    end else begin
      if (m_k == ROWS + 4) begin
        m_rdata = acc_data_out; m_rtile = m_tile;
      end
      if (m_k >= ROWS + 5) begin
        if (res_ready) begin
          if (m_tile == TILES - 1) m_done = 1;
          else begin m_tile++; m_k = 0; end
        end
      end else m_k++;
    end
    if (m_act && !m_done && m_k < ROWS) begin
      m_da = m_k; m_wa = m_tile * ROWS + m_k;
    end
  endfunction

  task automatic step();
    bit ph;
    @(posedge clk_h);
    m_step();
    #1;
    ph = m_act && !m_done;
    chk("busy", busy, m_act);
    chk("done", done, m_done);
    chk("mem_rd", mem_rd, ph && m_k < ROWS);
    chk("acc_clear", acc_clear, ph && m_k == 0);
    chk("acc_last_line", acc_last_line, ph && m_k == ROWS);
    chk("acc_wr", acc_wr, ph && m_k == ROWS + 3);
    chk("res_valid", res_valid, ph && m_k >= ROWS + 5);
    chk("data_addr", data_addr, m_da);
    chk("weight_addr", weight_addr, m_wa);
    chk("acc_th", acc_th, m_th);
    chk("res_data", res_data, m_rdata);
    chk("res_tile", res_tile, m_rtile);
  endtask

  typedef struct {
    int   cyc;
    logic busy, rd, clr, last, wr, valid, done;
    bit   chk_wa;
    int   wa;
    int   rtile;
  } vec_t;

  vec_t tv[$];

  function automatic void addv(int c, logic b, logic r, logic cl,
                               logic l, logic w, logic v, logic d,
                               bit cw, int wa, int rt);
    vec_t x;
    x.cyc = c; x.busy = b; x.rd = r; x.clr = cl; x.last = l;
    x.wr = w; x.valid = v; x.done = d; x.chk_wa = cw;
    x.wa = wa; x.rtile = rt;
    tv.push_back(x);
  endfunction

  task automatic wait_for(string nm, int which, int lim);
    bit hit;
    hit = 0;
    for (int n = 0; n < lim && !hit; n++) begin
      acc_data_out = $urandom;
      step();
      unique case (which)
        0: hit = res_valid;
        1: hit = acc_wr;
        2: hit = done;
        default: hit = acc_clear && (weight_addr == 3'd4);
      endcase
    end
    chk(nm, hit, 1'b1);
  endtask

  initial begin
    logic [DW-1:0] held;
    int cnt;
    m_reset();
    step(); step();
    rst = 1'b0;
    chk("reset_busy", busy, 1'b0);
    chk("reset_wa", weight_addr, 3'd0);
    chk("reset_valid", res_valid, 1'b0);

    // busy rd clr last wr valid done chk_wa wa tile
    addv(1,  1, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    addv(2,  1, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    addv(3,  1, 1, 0, 0, 0, 0, 0, 1, 2, 0);
    addv(4,  1, 1, 0, 0, 0, 0, 0, 1, 3, 0);
    addv(5,  1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    addv(8,  1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    addv(10, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    addv(11, 1, 1, 1, 0, 0, 0, 0, 1, 4, 0);
    addv(14, 1, 1, 0, 0, 0, 0, 0, 1, 7, 0);
    addv(15, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    addv(18, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    addv(20, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    addv(21, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    addv(22, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    th_cfg = 5'b10010; res_ready = 1'b1; start = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      acc_data_out = $urandom;
      step();
      start = 1'b0;
      th_cfg = 5'($urandom);
      foreach (tv[i]) if (tv[i].cyc == c) begin
        chk($sformatf("v%0d_busy", c), busy, tv[i].busy);
        chk($sformatf("v%0d_rd", c), mem_rd, tv[i].rd);
        chk($sformatf("v%0d_clr", c), acc_clear, tv[i].clr);
        chk($sformatf("v%0d_last", c), acc_last_line, tv[i].last);
        chk($sformatf("v%0d_wr", c), acc_wr, tv[i].wr);
        chk($sformatf("v%0d_valid", c), res_valid, tv[i].valid);
        chk($sformatf("v%0d_done", c), done, tv[i].done);
        chk($sformatf("v%0d_th", c), acc_th, 5'b10010);
        if (tv[i].chk_wa)
          chk($sformatf("v%0d_wa", c), weight_addr, tv[i].wa);
        if (tv[i].valid)
          chk($sformatf("v%0d_tile", c), res_tile, tv[i].rtile);
      end
    end

    // Back-pressure on tile 0, with an ignored start mid-frame.
    th_cfg = 5'h0B; res_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    wait_for("bp_valid", 0, 30);
    held = res_data;
    for (int n = 0; n < 5; n++) begin
      start = (n == 1); th_cfg = 5'h07;
      acc_data_out = $urandom;
      step();
      chk("bp_valid_held", res_valid, 1'b1);
      chk("bp_data_stable", res_data, held);
      chk("bp_no_read", mem_rd, 1'b0);
      chk("bp_th_kept", acc_th, 5'h0B);
    end
    start = 1'b0; res_ready = 1'b1;
    step();
    chk("bp_clear_next", acc_clear, 1'b1);
    chk("bp_wa_tile1", weight_addr, 3'd4);
    wait_for("bp_done", 2, 30);
    step();

    // Abort while streaming tile 1.
    start = 1'b1;
    step();
    start = 1'b0;
    wait_for("ab_tile1", 3, 30);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_busy", busy, 1'b0);
    chk("ab_rd", mem_rd, 1'b0);
    chk("ab_th", acc_th, 5'd0);
    cnt = 0;
    for (int n = 0; n < 25; n++) begin step(); cnt += int'(done); end
    chk("ab_no_done", cnt, 0);
    abort = 1'b1; start = 1'b1;
    step();
    chk("ab_start_ignored", busy, 1'b0);
    abort = 1'b0;
    step();
    chk("ab_restart_wa", weight_addr, 3'd0);
    chk("ab_restart_clr", acc_clear, 1'b1);
    start = 1'b0;

    // Reset while in WRITE.
    wait_for("rs_wr", 1, 30);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rs_busy", busy, 1'b0);
    chk("rs_wr_low", acc_wr, 1'b0);
    chk("rs_res_data", res_data, '0);
    cnt = 0;
    for (int n = 0; n < 20; n++) begin step(); cnt += int'(acc_wr); end
    chk("rs_no_wr", cnt, 0);

    for (int n = 0; n < 4000; n++) begin
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 63) == 0);
      rst = ($urandom_range(0, 255) == 0);
      res_ready = $urandom_range(0, 1);
      th_cfg = 5'($urandom);
      acc_data_out = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
